// File: rtl/mmu_fault_report.sv
`default_nettype none
// ============================================================================
// Module      : mmu_fault_report
// Description : Turns MMU permission-check results into bus strobes
//               (grant / berr) and captures the first denied access into a
//               fault status / fault address register pair. Later denials
//               that arrive while a fault is still unacknowledged are only
//               counted, in a saturating lost-fault counter.
// Revision    : 1.0 - initial release
// ============================================================================
module mmu_fault_report #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              chk_valid,
    input  logic              chk_allow,
    input  logic [4:0]        chk_fault,
    input  logic [2:0]        chk_req,
    input  logic              chk_is_user,
    input  logic [ADDR_W-1:0] chk_addr,
    input  logic              clr,
    input  logic              irq_en,
    output logic              grant,
    output logic              berr,
    output logic              pending,
    output logic              irq,
    output logic [8:0]        fsr,
    output logic [ADDR_W-1:0] far,
    output logic [CNT_W-1:0]  lost_cnt
);

    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_PEND = 1'b1;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic              r_grant;
    logic              r_berr;
    logic              r_irq;
    logic [8:0]        r_fsr;
    logic [ADDR_W-1:0] r_far;
    logic [CNT_W-1:0]  r_lost;

    logic              w_denied;
    logic              w_passed;
    logic              w_capture;
    logic              w_lost_inc;
    logic              w_lost_clr;

    // Qualified check outcomes; every other check field is ignored when chk_valid=0.
    always_comb begin
        w_denied = chk_valid & ~chk_allow;
        w_passed = chk_valid &  chk_allow;
    end

    // Next state plus capture and counter controls. A clear that collides with
    // a new denial re-arms on the new fault instead of dropping it.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_lost_inc  = 1'b0;
        w_lost_clr  = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (w_denied) begin
                    w_capture   = 1'b1;
                    w_state_nxt = c_S_PEND;
                end
            end
            c_S_PEND: begin
                if (clr) begin
                    w_lost_clr = 1'b1;
                    if (w_denied) begin
                        w_capture = 1'b1;
                    end else begin
                        w_state_nxt = c_S_IDLE;
                    end
                end else if (w_denied) begin
                    w_lost_inc = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // FSM state and one-cycle-latency bus strobes; berr is never gated by capture policy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
            r_grant <= 1'b0;
            r_berr  <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_passed;
            r_berr  <= w_denied;
            r_irq   <= (w_state_nxt == c_S_PEND) & irq_en;
        end
    end

    // Fault status / address capture; held across lost faults and after clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsr <= 9'd0;
            r_far <= {ADDR_W{1'b0}};
        end else if (w_capture) begin
            r_fsr <= {chk_is_user, chk_req, chk_fault};
            r_far <= chk_addr;
        end
    end

    // Saturating count of denials that could not be captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lost <= {CNT_W{1'b0}};
        end else if (w_lost_clr) begin
            r_lost <= {CNT_W{1'b0}};
        end else if (w_lost_inc && (r_lost != c_CNT_MAX)) begin
            r_lost <= r_lost + c_CNT_ONE;
        end
    end

    assign grant    = r_grant;
    assign berr     = r_berr;
    assign pending  = (r_state == c_S_PEND);
    assign irq      = r_irq;
    assign fsr      = r_fsr;
    assign far      = r_far;
    assign lost_cnt = r_lost;

endmodule
`default_nettype wire

// File: tb/tb_mmu_fault_report.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmu_fault_report
// Description : Directed self-checking bench for mmu_fault_report.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmu_fault_report;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst_n;
    logic              chk_valid;
    logic              chk_allow;
    logic [4:0]        chk_fault;
    logic [2:0]        chk_req;
    logic              chk_is_user;
    logic [ADDR_W-1:0] chk_addr;
    logic              clr;
    logic              irq_en;
    logic              grant;
    logic              berr;
    logic              pending;
    logic              irq;
    logic [8:0]        fsr;
    logic [ADDR_W-1:0] far;
    logic [CNT_W-1:0]  lost_cnt;

    int n_total;
    int n_bad;
    int berr_pulses;

    mmu_fault_report #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .chk_valid   (chk_valid),
        .chk_allow   (chk_allow),
        .chk_fault   (chk_fault),
        .chk_req     (chk_req),
        .chk_is_user (chk_is_user),
        .chk_addr    (chk_addr),
        .clr         (clr),
        .irq_en      (irq_en),
        .grant       (grant),
        .berr        (berr),
        .pending     (pending),
        .irq         (irq),
        .fsr         (fsr),
        .far         (far),
        .lost_cnt    (lost_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        chk_valid   = 1'b0;
        chk_allow   = 1'b0;
        chk_fault   = 5'd0;
        chk_req     = 3'd0;
        chk_is_user = 1'b0;
        chk_addr    = '0;
        clr         = 1'b0;
    endtask

    task automatic deny(input logic usr, input logic [2:0] req, input logic [4:0] flt,
                        input logic [ADDR_W-1:0] addr);
        chk_valid   = 1'b1;
        chk_allow   = 1'b0;
        chk_is_user = usr;
        chk_req     = req;
        chk_fault   = flt;
        chk_addr    = addr;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".grant"},   64'(grant),    64'd0);
        check({tag, ".berr"},    64'(berr),     64'd0);
        check({tag, ".pending"}, 64'(pending),  64'd0);
        check({tag, ".irq"},     64'(irq),      64'd0);
        check({tag, ".fsr"},     64'(fsr),      64'd0);
        check({tag, ".far"},     64'(far),      64'd0);
        check({tag, ".lost"},    64'(lost_cnt), 64'd0);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        irq_en  = 1'b0;
        idle_inputs();

        // Reset state, with a denied check presented that must be ignored.
        deny(1'b1, 3'b111, 5'b11111, 32'hDEAD_BEEF);
        tick();
        tick();
        check_all_zero("reset");
        idle_inputs();
        rst_n = 1'b1;

        // Allowed check: grant for exactly one cycle, nothing captured.
        chk_valid = 1'b1;
        chk_allow = 1'b1;
        chk_addr  = 32'h0000_1234;
        tick();
        idle_inputs();
        check("pass.grant",   64'(grant),   64'd1);
        check("pass.berr",    64'(berr),    64'd0);
        check("pass.pending", 64'(pending), 64'd0);
        check("pass.fsr",     64'(fsr),     64'd0);
        tick();
        check("pass.grant_off", 64'(grant), 64'd0);

        // Invalid check with junk fields is ignored.
        chk_fault = 5'b11111;
        chk_addr  = 32'hFFFF_FFFF;
        tick();
        idle_inputs();
        check("inval.berr",    64'(berr),    64'd0);
        check("inval.pending", 64'(pending), 64'd0);
        check("inval.far",     64'(far),     64'd0);

        // First fault, irq_en=0.
        deny(1'b1, 3'b010, 5'b01010, 32'h0000_4000);
        tick();
        idle_inputs();
        check("f1.berr",    64'(berr),     64'd1);
        check("f1.grant",   64'(grant),    64'd0);
        check("f1.pending", 64'(pending),  64'd1);
        check("f1.fsr",     64'(fsr),      64'h14A);
        check("f1.far",     64'(far),      64'h4000);
        check("f1.irq",     64'(irq),      64'd0);
        check("f1.lost",    64'(lost_cnt), 64'd0);
        tick();
        check("f1.berr_off", 64'(berr), 64'd0);

        // Interrupt gating: enable while pending -> irq next cycle.
        irq_en = 1'b1;
        tick();
        check("irq.on", 64'(irq), 64'd1);

        // Passed check during pending leaves capture alone.
        chk_valid = 1'b1;
        chk_allow = 1'b1;
        chk_addr  = 32'h0000_9999;
        tick();
        idle_inputs();
        check("pp.grant",   64'(grant),   64'd1);
        check("pp.far",     64'(far),     64'h4000);
        check("pp.pending", 64'(pending), 64'd1);

        // Lost faults: 20 denials, counter saturates at 15.
        berr_pulses = 0;
        for (int i = 0; i < 20; i++) begin
            deny(1'b0, 3'b001, 5'b00001, 32'h0000_0100 + 32'(i));
            tick();
            if (berr === 1'b1) berr_pulses++;
            check("lost.cnt", 64'(lost_cnt), 64'((i + 1 > 15) ? 15 : i + 1));
        end
        idle_inputs();
        check("lost.berrs", 64'(berr_pulses), 64'd20);
        check("lost.far",   64'(far),         64'h4000);
        check("lost.fsr",   64'(fsr),         64'h14A);

        // Clear collides with a new denial at 0x10.
        clr = 1'b1;
        deny(1'b0, 3'b100, 5'b00100, 32'h0000_0010);
        tick();
        idle_inputs();
        check("col.pending", 64'(pending),  64'd1);
        check("col.far",     64'(far),      64'h10);
        check("col.fsr",     64'(fsr),      64'h084);
        check("col.lost",    64'(lost_cnt), 64'd0);
        check("col.berr",    64'(berr),     64'd1);
        check("col.irq",     64'(irq),      64'd1);

        // Clear alone: back to idle, registers retained.
        clr = 1'b1;
        tick();
        idle_inputs();
        check("clr.pending", 64'(pending), 64'd0);
        check("clr.far",     64'(far),     64'h10);
        check("clr.irq",     64'(irq),     64'd0);

        // Clear in idle does nothing.
        clr = 1'b1;
        tick();
        idle_inputs();
        check("iclr.pending", 64'(pending), 64'd0);
        check("iclr.far",     64'(far),     64'h10);

        // Capture with irq_en=1: irq rises with pending; disable drops it next cycle.
        deny(1'b1, 3'b001, 5'b10000, 32'h0000_0020);
        tick();
        idle_inputs();
        check("irq2.pending", 64'(pending), 64'd1);
        check("irq2.irq",     64'(irq),     64'd1);
        irq_en = 1'b0;
        tick();
        check("irq2.off", 64'(irq), 64'd0);
        check("irq2.hold", 64'(pending), 64'd1);

        // Async reset between edges while pending, with a denial in flight.
        irq_en = 1'b1;
        tick();
        deny(1'b1, 3'b111, 5'b00010, 32'h0000_0030);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("areset");
        tick();
        check_all_zero("areset_hold");

        // First check after release is the one sampled at the first rising edge.
        rst_n = 1'b1;
        deny(1'b0, 3'b010, 5'b01000, 32'h0000_0040);
        tick();
        idle_inputs();
        check("post.berr",    64'(berr),    64'd1);
        check("post.pending", 64'(pending), 64'd1);
        check("post.far",     64'(far),     64'h40);
        check("post.fsr",     64'(fsr),     64'h048);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
